// File: rtl/dff_skid.sv
// Registered valid/ready stage with a one-word skid buffer: data, valid and
// ready are all flops, so no combinational path crosses between the two sides.
package dffx;
  typedef int unsigned dff_bits_count;
endpackage

module dff_skid #(
  parameter dffx::dff_bits_count BITS_COUNT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BITS_COUNT-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BITS_COUNT-1:0] m_data,
  output logic [1:0]            count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [BITS_COUNT-1:0]   main_p0, skid_p0;
  logic                    in_fire, out_fire;
  logic                    load_main_in, load_main_skid, load_skid;

  assign in_fire  = s_valid & s_ready;
  assign out_fire = m_valid & m_ready;
  assign m_data   = main_p0;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = TWO;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Control flops mirror the decode of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= EMPTY;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      count   <= 2'd0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt != TWO);
      m_valid <= (state_nxt != EMPTY);
      count   <= (state_nxt == TWO) ? 2'd2 : (state_nxt == ONE) ? 2'd1 : 2'd0;
    end
  end

  // Stage 0: main and skid word registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_p0 <= '0;
      skid_p0 <= '0;
    end else begin
      if (load_main_in)
        main_p0 <= s_data;
      else if (load_main_skid)
        main_p0 <= skid_p0;
      if (load_skid)
        skid_p0 <= s_data;
    end
  end

  a_count_max: assert property (@(posedge clk) count <= 2'd2);
  a_valid_count: assert property (@(posedge clk) m_valid == (count != 2'd0));
  a_ready_count: assert property (@(posedge clk) disable iff (!reset_n)
                                  $past(reset_n) |-> (s_ready == (count != 2'd2)));

endmodule

// File: tb/tb_dff_skid.sv
// Bench for dff_skid: vector table, streaming run, and a randomized run
// scoreboarded against a FIFO-of-depth-two reference model.
module tb_dff_skid;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] count;

  int checks = 0;
  int passes = 0;

  dff_skid #(.BITS_COUNT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       er;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst_n, logic sv, logic [7:0] sd, logic mr,
                              logic er, logic ev, logic [7:0] ed, logic [1:0] ec);
    vec_t v;
    v.rst_n = rst_n; v.sv = sv; v.sd = sd; v.mr = mr;
    v.er = er; v.ev = ev; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic sv, input logic [7:0] sd, input logic mr);
    reset_n = r; s_valid = sv; s_data = sd; m_ready = mr;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  bit         rdy_ok;
  bit         exp_sr, exp_mv, stalled;
  logic [7:0] held;
  logic       rsv, rmr;
  logic [7:0] rsd;

  initial begin
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    // reset with s_valid high, release, stall A1..A3, drain
    repeat (3) tbl.push_back(mk(0, 1, 8'h11, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 8'h22, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 8'hA1, 0, 1, 1, 8'hA1, 1));
    tbl.push_back(mk(1, 1, 8'hA2, 0, 0, 1, 8'hA1, 2));
    tbl.push_back(mk(1, 1, 8'hA3, 0, 0, 1, 8'hA1, 2));
    tbl.push_back(mk(1, 1, 8'hA3, 1, 1, 1, 8'hA2, 1));
    tbl.push_back(mk(1, 1, 8'hA3, 1, 1, 1, 8'hA3, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 8'hA3, 0));
    // fill TWO with 5A,C3 then drain 3 cycles
    tbl.push_back(mk(1, 1, 8'h5A, 0, 1, 1, 8'h5A, 1));
    tbl.push_back(mk(1, 1, 8'hC3, 0, 0, 1, 8'h5A, 2));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 1, 8'hC3, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 8'hC3, 0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 8'hC3, 0));
    // reset while in TWO, then 0x77 alone
    tbl.push_back(mk(1, 1, 8'hB1, 0, 1, 1, 8'hB1, 1));
    tbl.push_back(mk(1, 1, 8'hB2, 0, 0, 1, 8'hB1, 2));
    tbl.push_back(mk(0, 1, 8'hB3, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 8'h77, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 8'h77, 0, 1, 1, 8'h77, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 8'h77, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].sv, tbl[i].sd, tbl[i].mr);
      chk($sformatf("vec%0d s_ready", i), s_ready, tbl[i].er);
      chk($sformatf("vec%0d m_valid", i), m_valid, tbl[i].ev);
      chk($sformatf("vec%0d m_data", i), m_data, tbl[i].ed);
      chk($sformatf("vec%0d count", i), count, tbl[i].ec);
    end

    // streaming 0x01..0x10 with consumer always ready
    for (int i = 1; i <= 16; i++) begin
      step(1, 1, 8'(i), 1);
      chk($sformatf("stream%0d m_data", i), m_data, i);
      chk($sformatf("stream%0d m_valid", i), m_valid, 1);
      chk($sformatf("stream%0d count", i), count, 1);
      chk($sformatf("stream%0d s_ready", i), s_ready, 1);
    end
    step(1, 0, 8'h00, 1);
    chk("stream_end m_valid", m_valid, 0);
    chk("stream_end count", count, 0);

    // randomized run against the queue model
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    q.delete();
    rdy_ok = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      rsv = 1'($urandom_range(0, 1));
      rmr = 1'($urandom_range(0, 1));
      rsd = 8'($urandom);
      exp_sr  = rdy_ok && (q.size() < 2);
      exp_mv  = (q.size() > 0);
      stalled = exp_mv && !rmr;
      held    = exp_mv ? q[0] : 8'h00;
      step(1, rsv, rsd, rmr);
      if (exp_mv && rmr) void'(q.pop_front());
      if (exp_sr && rsv) q.push_back(rsd);
      rdy_ok = 1'b1;
      chk("rand s_ready", s_ready, (q.size() < 2) ? 1 : 0);
      chk("rand m_valid", m_valid, (q.size() > 0) ? 1 : 0);
      chk("rand count", count, q.size());
      if (q.size() > 0) chk("rand m_data", m_data, q[0]);
      if (stalled) chk("rand stall hold", m_data, held);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
